// File: rtl/wt_loader_pkg.sv
// wt_loader_pkg: shared state types for the weight tile loader.
package wt_loader_pkg;
  typedef enum logic {L_IDLE, L_FILL} load_state_t;
  typedef enum logic {D_IDLE, D_RUN} drain_state_t;
endpackage

// File: rtl/wt_bank_regs.sv
// wt_bank_regs: two-bank NxN weight store with one write port and a per-column row-select read.
module wt_bank_regs
  import wt_loader_pkg::*;
#(
  parameter int N_COLS = 3,
  parameter int DATA_W = 8,
  localparam int AW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic                       wr_bank,
  input  logic [AW-1:0]              wr_row,
  input  logic [AW-1:0]              wr_col,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_bank,
  input  logic [N_COLS*N_COLS-1:0]   rd_sel,
  output logic [N_COLS*DATA_W-1:0]   rd_data
);
  logic [DATA_W-1:0] mem [2][N_COLS][N_COLS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_row][wr_col] <= wr_data;
  end

  // rd_sel bit c*N+r picks row r for column c; an all-zero group drives 0
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_COLS; c++)
      for (int r = 0; r < N_COLS; r++)
        if (rd_sel[c*N_COLS+r]) rd_data[c*DATA_W +: DATA_W] = rd_data[c*DATA_W +: DATA_W] | mem[rd_bank][r][c];
  end
endmodule

// File: rtl/wt_tile_loader.sv
// wt_tile_loader: double-banked weight tile buffer; fills one bank while draining the other
// as a diagonally skewed per-column stream.
module wt_tile_loader
  import wt_loader_pkg::*;
#(
  parameter int N_COLS = 3,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic [7:0]               cfg_num_tiles,
  input  logic                     cfg_transpose,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_start,
  output logic [N_COLS*DATA_W-1:0] out_wt,
  output logic [N_COLS-1:0]        out_valid,
  output logic                     out_last,
  output logic                     tile_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     drain_busy,
  output logic                     err_underrun
);
  localparam int AW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int TW = $clog2(2*N_COLS);
  localparam logic [AW-1:0] LAST = AW'(N_COLS-1);
  localparam logic [TW-1:0] T_END = TW'(2*N_COLS-2);

  load_state_t l_state, l_nxt;
  drain_state_t d_state, d_nxt;
  logic [7:0] tiles_left, tl_nxt;
  logic transpose, tr_nxt;
  logic [AW-1:0] i, o, i_nxt, o_nxt;
  logic wr_bank, wb_nxt, rd_bank, rb_nxt;
  logic [1:0] full, full_nxt;
  logic [TW-1:0] t, t_nxt;
  logic set_full, clr_full, done_nxt, err_nxt, accept;
  logic [N_COLS*N_COLS-1:0] rd_sel;
  logic [N_COLS*DATA_W-1:0] rd_data;
  logic [N_COLS-1:0] valid_nxt;

  assign in_ready = (l_state == L_FILL) && !full[wr_bank];
  assign accept = in_valid && in_ready;
  assign tile_ready = |full;
  assign load_busy = (l_state == L_FILL);
  assign drain_busy = (d_state == D_RUN);

  wt_bank_regs #(.N_COLS(N_COLS), .DATA_W(DATA_W)) u_banks (
    .clk     (clk),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_row  (transpose ? o : i),
    .wr_col  (transpose ? i : o),
    .wr_data (in_data),
    .rd_bank (rd_bank),
    .rd_sel  (rd_sel),
    .rd_data (rd_data)
  );

  always_comb begin
    l_nxt = l_state;
    tl_nxt = tiles_left;
    tr_nxt = transpose;
    i_nxt = i;
    o_nxt = o;
    wb_nxt = wr_bank;
    set_full = 1'b0;
    done_nxt = 1'b0;
    if (l_state == L_IDLE && cfg_start) begin
      tl_nxt = cfg_num_tiles;
      tr_nxt = cfg_transpose;
      l_nxt = (cfg_num_tiles == 8'd0) ? L_IDLE : L_FILL;
      done_nxt = (cfg_num_tiles == 8'd0);
    end else if (accept) begin
      i_nxt = (i == LAST) ? '0 : i + 1'b1;
      o_nxt = (i != LAST) ? o : (o == LAST) ? '0 : o + 1'b1;
      if (i == LAST && o == LAST) begin
        set_full = 1'b1;
        wb_nxt = ~wr_bank;
        tl_nxt = tiles_left - 8'd1;
        l_nxt = (tiles_left == 8'd1) ? L_IDLE : L_FILL;
        done_nxt = (tiles_left == 8'd1);
      end
    end
  end

  // drain samples the registered full flag, so a bank completing this cycle is not yet drainable
  always_comb begin
    d_nxt = d_state;
    t_nxt = t;
    rb_nxt = rd_bank;
    clr_full = 1'b0;
    err_nxt = 1'b0;
    if (d_state == D_IDLE) begin
      if (drain_start) begin
        d_nxt = full[rd_bank] ? D_RUN : D_IDLE;
        err_nxt = !full[rd_bank];
        t_nxt = '0;
      end
    end else if (t == T_END) begin
      d_nxt = D_IDLE;
      clr_full = 1'b1;
      rb_nxt = ~rd_bank;
      t_nxt = '0;
    end else begin
      t_nxt = t + 1'b1;
    end
  end

  // outputs are registered, so the read is addressed by the step about to be presented
  always_comb begin
    rd_sel = '0;
    valid_nxt = '0;
    for (int c = 0; c < N_COLS; c++)
      for (int r = 0; r < N_COLS; r++) begin
        rd_sel[c*N_COLS+r] = (d_nxt == D_RUN) && (t_nxt == TW'(c + r));
        valid_nxt[c] = valid_nxt[c] | rd_sel[c*N_COLS+r];
      end
  end

  always_comb begin
    full_nxt = full;
    if (clr_full) full_nxt[rd_bank] = 1'b0;
    if (set_full) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_state <= L_IDLE;
      tiles_left <= '0;
      transpose <= 1'b0;
      i <= '0;
      o <= '0;
      wr_bank <= 1'b0;
      load_done <= 1'b0;
    end else begin
      l_state <= l_nxt;
      tiles_left <= tl_nxt;
      transpose <= tr_nxt;
      i <= i_nxt;
      o <= o_nxt;
      wr_bank <= wb_nxt;
      load_done <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_state <= D_IDLE;
      t <= '0;
      rd_bank <= 1'b0;
      full <= '0;
      err_underrun <= 1'b0;
      out_wt <= '0;
      out_valid <= '0;
      out_last <= 1'b0;
    end else begin
      d_state <= d_nxt;
      t <= t_nxt;
      rd_bank <= rb_nxt;
      full <= full_nxt;
      err_underrun <= err_nxt;
      out_wt <= rd_data;
      out_valid <= valid_nxt;
      out_last <= (d_nxt == D_RUN) && (t_nxt == T_END);
    end
  end
endmodule

// File: tb/tb_wt_tile_loader.sv
// tb_wt_tile_loader: directed scenarios checked every cycle against a queue-of-tiles model.
module tb_wt_tile_loader;
  localparam int N = 3;
  localparam int DW = 8;
  typedef logic [N*N*DW-1:0] tile_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_transpose = 1'b0, in_valid = 1'b0, drain_start = 1'b0;
  logic [7:0] cfg_num_tiles = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_last, tile_ready, load_busy, load_done, drain_busy, err_underrun;
  logic [N*DW-1:0] out_wt;
  logic [N-1:0] out_valid;

  wt_tile_loader #(.N_COLS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_tiles(cfg_num_tiles),
    .cfg_transpose(cfg_transpose), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .drain_start(drain_start), .out_wt(out_wt), .out_valid(out_valid), .out_last(out_last),
    .tile_ready(tile_ready), .load_busy(load_busy), .load_done(load_done),
    .drain_busy(drain_busy), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // model: completed tiles wait in a FIFO of at most two; a drain presents the head tile skewed
  int cyc = 0;
  bit m_load, m_tr, m_drain, e_done, e_err;
  int m_left, m_k, d_start;
  tile_t cur, d_tile;
  tile_t tq[$];

  always @(posedge clk) begin
    int nfull, r, c;
    bit acc, ds;
    if (!rst_n) begin
      m_load = 0; m_tr = 0; m_drain = 0; e_done = 0; e_err = 0;
      m_left = 0; m_k = 0; tq.delete();
    end else begin
      nfull = tq.size();
      acc = in_valid && m_load && nfull < 2;
      ds = drain_start && !m_drain;
      e_done = 0;
      e_err = 0;
      if (m_drain && cyc == d_start + 2*N - 1) begin
        void'(tq.pop_front());
        m_drain = 0;
      end
      if (ds) begin
        if (nfull > 0) begin m_drain = 1; d_start = cyc; d_tile = tq[0]; end
        else e_err = 1;
      end
      if (!m_load && cfg_start) begin
        m_tr = cfg_transpose; m_left = cfg_num_tiles; m_k = 0;
        if (cfg_num_tiles == 0) e_done = 1; else m_load = 1;
      end else if (acc) begin
        r = m_tr ? m_k / N : m_k % N;
        c = m_tr ? m_k % N : m_k / N;
        cur[(r*N+c)*DW +: DW] = in_data;
        m_k++;
        if (m_k == N*N) begin
          tq.push_back(cur);
          m_k = 0;
          m_left--;
          if (m_left == 0) begin m_load = 0; e_done = 1; end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [N*DW-1:0] exp_wt;
    logic [N-1:0] exp_v;
    int p;
    if (!rst_n) begin
      chk("reset_outputs", {out_wt, out_valid, out_last, load_done, err_underrun, tile_ready,
          load_busy, drain_busy, in_ready}, 64'd0);
    end else begin
      exp_wt = '0;
      exp_v = '0;
      p = cyc - d_start - 1;
      if (m_drain)
        for (int c = 0; c < N; c++)
          if (p >= c && p <= c + N - 1) begin
            exp_v[c] = 1'b1;
            exp_wt[c*DW +: DW] = d_tile[((p-c)*N+c)*DW +: DW];
          end
      chk("out_wt", out_wt, exp_wt);
      chk("out_valid", out_valid, exp_v);
      chk("out_last", out_last, m_drain && p == 2*N-2);
      chk("in_ready", in_ready, m_load && tq.size() < 2);
      chk("tile_ready", tile_ready, tq.size() > 0);
      chk("load_busy", load_busy, m_load);
      chk("drain_busy", drain_busy, m_drain);
      chk("load_done", load_done, e_done);
      chk("err_underrun", err_underrun, e_err);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cfg(input int num, input bit tr);
    cfg_num_tiles = 8'(num);
    cfg_transpose = tr;
    cfg_start = 1;
    step(1);
    cfg_start = 0;
  endtask

  task automatic feed(input int base, input int count);
    for (int k = 0; k < count; k++) begin
      int w = 0;
      bit acc = 0;
      in_valid = 1;
      in_data = 8'(base + k);
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #2;
        w++;
        if (!acc && w > 100) begin
          total++; bad++;
          $display("FAIL feed_timeout at %0t: got no accept want accept", $time);
          in_valid = 0;
          return;
        end
      end
    end
    in_valid = 0;
  endtask

  task automatic load(input int num, input bit tr, input int base, input bit pin);
    cfg(num, tr);
    feed(base, num*N*N);
    if (pin) begin @(negedge clk); chk("load_done_pin", load_done, 1); end
  endtask

  task automatic drain();
    drain_start = 1;
    step(1);
    drain_start = 0;
    step(2*N);
  endtask

  task automatic drain_pin(input logic [23:0] w1, input logic [23:0] w3, input logic [23:0] w5);
    drain_start = 1;
    step(1);
    drain_start = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin chk("pin_wt1", out_wt, w1); chk("pin_v1", out_valid, 3'b001); end
      if (k == 3) begin chk("pin_wt3", out_wt, w3); chk("pin_v3", out_valid, 3'b111); end
      if (k == 5) begin chk("pin_wt5", out_wt, w5); chk("pin_v5", out_valid, 3'b100); chk("pin_last", out_last, 1); end
    end
    step(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got no finish want finish", $time);
    $fatal(1);
  end

  initial begin
    step(3);
    rst_n = 1;
    step(2);
    load(1, 0, 1, 1);
    step(1);
    drain_pin(24'h000001, 24'h070503, 24'h090000);
    load(1, 1, 1, 0);
    drain_pin(24'h000001, 24'h030507, 24'h090000);
    fork
      load(3, 0, 20, 1);
      begin
        step(30);
        @(negedge clk);
        chk("s3_stall_ready", in_ready, 0);
        chk("s3_both_full", tile_ready, 1);
        drain();
      end
    join
    chk("s3_wr_bank", dut.wr_bank, 1);
    drain();
    drain();
    drain_start = 1;
    step(1);
    drain_start = 0;
    @(negedge clk);
    chk("s4_err", err_underrun, 1);
    chk("s4_valid", out_valid, 0);
    step(1);
    cfg(0, 0);
    @(negedge clk);
    chk("s4_done_zero", load_done, 1);
    step(3);
    load(1, 0, 30, 0);
    fork
      drain();
      load(1, 0, 40, 0);
    join
    drain();
    @(negedge clk);
    chk("s5_empty", tile_ready, 0);
    step(2);
    cfg(1, 0);
    feed(50, 5);
    rst_n = 0;
    @(negedge clk);
    chk("s6_rst_busy", load_busy, 0);
    step(2);
    rst_n = 1;
    step(1);
    chk("s6_no_stale", tile_ready, 0);
    load(1, 0, 10, 0);
    drain_pin(24'h00000a, 24'h100e0c, 24'h120000);
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
